// File: rtl/uart_pkg.sv
// Register map, status bit positions and FSM encodings
// shared by fifo_uart and its bench.
package uart_pkg;

  localparam logic [1:0] A_TXDR = 2'd0;
  localparam logic [1:0] A_RXDR = 2'd1;
  localparam logic [1:0] A_CFG  = 2'd2;
  localparam logic [1:0] A_SR   = 2'd3;

  localparam int SR_BUSY  = 0;
  localparam int SR_RXNE  = 1;
  localparam int SR_TXF   = 2;
  localparam int SR_FE    = 3;
  localparam int SR_RXOVR = 4;
  localparam int SR_PE    = 5;
  localparam int SR_TXOVR = 6;
  localparam int SR_RXF   = 7;

  localparam int CFG_PEN = 16;
  localparam int CFG_ODD = 17;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_st_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_st_e;

  function automatic logic par_bit(
    input logic [7:0] d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_if.sv
// Peripheral bus window of fifo_uart: one access
// per cycle while sel_i is high, read data registered.
interface fifo_uart_if;
  logic        sel_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output sel_i, we_i, addr_i, data_i,
    input  data_o
  );

  modport slave (
    input  sel_i, we_i, addr_i, data_i,
    output data_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, AW+1 bit pointers, combinational head.
// Simultaneous push/pop always succeeds, also when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fifo_uart.sv
// Buffered UART: TX/RX FIFOs, baud tick, majority-vote RX.
// Parity (CFG PEN/ODD) only when built with UART_PARITY_EN.
module fifo_uart
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int OVS     = 8,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  fifo_uart_if.slave bus,
  output logic       txd_o,
  input  logic       rxd_i
);
  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OV_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] S0 = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] S1 = OW'(OVS / 2);
  localparam logic [OW-1:0] S2 = OW'(OVS / 2 + 1);

  logic wr, rd, cfg_wr, sr_wr;
  logic [DIV_W-1:0] div, tcnt;
  logic tick, pen, odd;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;
  logic fe, rxovr, pe, txovr, fe_set, pe_set;
  logic [31:0] sr, cfg_rd, rd_d, rdata;
  logic unused;

  assign wr      = bus.sel_i & bus.we_i;
  assign rd      = bus.sel_i & ~bus.we_i;
  assign cfg_wr  = wr && bus.addr_i == A_CFG;
  assign sr_wr   = wr && bus.addr_i == A_SR;
  assign tx_push = wr && bus.addr_i == A_TXDR;
  assign rx_pop  = rd && bus.addr_i == A_RXDR;
  assign unused  = ^bus.data_i;
  assign tick    = tcnt >= div;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tcnt <= '0;
      div  <= DIV_W'(DIV_RST);
    end else begin
      tcnt <= (cfg_wr || tick) ? '0 : tcnt + 1'b1;
      if (cfg_wr) div <= bus.data_i[DIV_W-1:0];
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pen <= 1'b0;
      odd <= 1'b0;
    end else if (cfg_wr) begin
      pen <= bus.data_i[CFG_PEN];
      odd <= bus.data_i[CFG_ODD];
    end
  end
`else
  assign pen = 1'b0;
  assign odd = 1'b0;
`endif

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_txf (
    .clk_i, .rst_i,
    .push (tx_push), .pop  (tx_pop),
    .din  (bus.data_i[7:0]), .dout (tx_dout),
    .full (tx_full), .empty(tx_empty)
  );

  // ---- transmitter ----
  tx_st_e tx_st, tx_nx;
  logic [OW-1:0] tx_ov, tx_ov_d;
  logic [2:0] tx_bit, tx_bit_d;
  logic [7:0] tx_sh, tx_sh_d;
  logic tx_par, tx_par_d, txd_d, tx_last;

  assign tx_last = tick && tx_ov == OV_LAST;

  always_comb begin
    tx_nx    = tx_st;
    tx_ov_d  = tx_ov;
    tx_bit_d = tx_bit;
    tx_sh_d  = tx_sh;
    tx_par_d = tx_par;
    tx_pop   = 1'b0;
    if (tick) tx_ov_d = (tx_ov == OV_LAST) ? '0 : tx_ov + 1'b1;
    unique case (tx_st)
      TX_IDLE: tx_ov_d = '0;
      TX_START: if (tx_last) tx_nx = TX_DATA;
      TX_DATA: if (tx_last) begin
        tx_sh_d  = {1'b0, tx_sh[7:1]};
        tx_bit_d = tx_bit + 1'b1;
        if (tx_bit == 3'd7) tx_nx = pen ? TX_PAR : TX_STOP;
      end
      TX_PAR: if (tx_last) tx_nx = TX_STOP;
      TX_STOP: if (tx_last) tx_nx = TX_IDLE;
      default: tx_nx = TX_IDLE;
    endcase
    // next frame starts on the stop's final tick: no idle gap
    if (tick && !tx_empty &&
        (tx_st == TX_IDLE || (tx_st == TX_STOP && tx_last))) begin
      tx_pop   = 1'b1;
      tx_nx    = TX_START;
      tx_ov_d  = '0;
      tx_bit_d = '0;
      tx_sh_d  = tx_dout;
      tx_par_d = par_bit(tx_dout, odd);
    end
    unique case (tx_nx)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_sh_d[0];
      TX_PAR:   txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_st  <= TX_IDLE;
      tx_ov  <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
      txd_o  <= 1'b1;
    end else begin
      tx_st  <= tx_nx;
      tx_ov  <= tx_ov_d;
      tx_bit <= tx_bit_d;
      tx_sh  <= tx_sh_d;
      tx_par <= tx_par_d;
      txd_o  <= txd_d;
    end
  end

  // ---- receiver ----
  rx_st_e rx_st, rx_nx;
  logic [1:0] rx_sync, vote, vote_d;
  logic [OW-1:0] rx_ov, rx_ov_d, rx_idx;
  logic [2:0] rx_bit, rx_bit_d;
  logic [7:0] rx_sh, rx_sh_d;
  logic rx_s, rx_last, maj, mid;

  assign rx_s   = rx_sync[1];
  assign rx_idx = (rx_ov == OV_LAST) ? '0 : rx_ov + 1'b1;
  assign mid    = tick && rx_idx == S2;
  assign maj    = (vote[0] & vote[1]) | (vote[0] & rx_s) |
                  (vote[1] & rx_s);

  always_comb begin
    rx_nx    = rx_st;
    rx_ov_d  = rx_ov;
    rx_bit_d = rx_bit;
    rx_sh_d  = rx_sh;
    vote_d   = vote;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    pe_set   = 1'b0;
    if (tick) begin
      rx_ov_d = rx_idx;
      if (rx_idx == S0) vote_d[0] = rx_s;
      if (rx_idx == S1) vote_d[1] = rx_s;
    end
    // states advance at mid-bit; the tick counter keeps running
    unique case (rx_st)
      RX_IDLE: begin
        rx_ov_d = '0;
        if (tick && rx_last && !rx_s) rx_nx = RX_START;
      end
      RX_START: if (mid) begin
        rx_nx    = maj ? RX_IDLE : RX_DATA;
        rx_bit_d = '0;
      end
      RX_DATA: if (mid) begin
        rx_sh_d  = {maj, rx_sh[7:1]};
        rx_bit_d = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_nx = pen ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (mid) begin
        pe_set = maj != par_bit(rx_sh, odd);
        rx_nx  = RX_STOP;
      end
      RX_STOP: if (mid) begin
        rx_push = 1'b1;
        fe_set  = !maj;
        rx_nx   = RX_IDLE;
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_sync <= 2'b11;
      rx_last <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_ov   <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      vote    <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rxd_i};
      if (tick) rx_last <= rx_s;
      rx_st   <= rx_nx;
      rx_ov   <= rx_ov_d;
      rx_bit  <= rx_bit_d;
      rx_sh   <= rx_sh_d;
      vote    <= vote_d;
    end
  end

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rxf (
    .clk_i, .rst_i,
    .push (rx_push), .pop  (rx_pop),
    .din  (rx_sh), .dout (rx_dout),
    .full (rx_full), .empty(rx_empty)
  );

  // ---- registers ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fe    <= 1'b0;
      rxovr <= 1'b0;
      pe    <= 1'b0;
      txovr <= 1'b0;
    end else begin
      if (sr_wr) begin
        fe    <= fe & ~bus.data_i[SR_FE];
        rxovr <= rxovr & ~bus.data_i[SR_RXOVR];
        pe    <= pe & ~bus.data_i[SR_PE];
        txovr <= txovr & ~bus.data_i[SR_TXOVR];
      end
      if (fe_set) fe <= 1'b1;
      if (pe_set) pe <= 1'b1;
      if (rx_push && rx_full && !rx_pop) rxovr <= 1'b1;
      if (tx_push && tx_full && !tx_pop) txovr <= 1'b1;
    end
  end

  always_comb begin
    sr = '0;
    sr[SR_BUSY]  = !tx_empty || tx_st != TX_IDLE;
    sr[SR_RXNE]  = !rx_empty;
    sr[SR_TXF]   = tx_full;
    sr[SR_FE]    = fe;
    sr[SR_RXOVR] = rxovr;
    sr[SR_PE]    = pe;
    sr[SR_TXOVR] = txovr;
    sr[SR_RXF]   = rx_full;
    cfg_rd = '0;
    cfg_rd[DIV_W-1:0] = div;
    cfg_rd[CFG_PEN]   = pen;
    cfg_rd[CFG_ODD]   = odd;
    rd_d = '0;
    unique case (bus.addr_i)
      A_TXDR: rd_d = '0;
      A_RXDR: rd_d = rx_empty ? '0 : {24'b0, rx_dout};
      A_CFG:  rd_d = cfg_rd;
      A_SR:   rd_d = sr;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)  rdata <= '0;
    else if (rd) rdata <= rd_d;
  end

  assign bus.data_o = rdata;
endmodule
